// File: rtl/lz77_pkg.sv
// Shared definitions for the LZ77 stream decoder: FSM encoding and default widths.
package lz77_pkg;

    localparam int unsigned CharW = 8;
    localparam logic [CharW-1:0] TermDefault = 8'h24;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCopy = 2'd1,
        StLit  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/lz77_search_buf.sv
// LZ77 search buffer: shift register of recently emitted chars.
// It has a combinational read port, and entry 0 holds the most recent char.
module lz77_search_buf #(
    parameter int unsigned CHAR_W = 8,
    parameter int unsigned DEPTH  = 9,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [CHAR_W-1:0] shift_in,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [CHAR_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (shift_en) begin
            mem_d[0] = shift_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Out-of-range indices read as zero rather than aliasing onto a real entry.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/lz77_stream_decoder.sv
// LZ77 tuple-to-char stream decoder with valid/ready on both sides.
// It also detects the literal terminator and flags out-of-range copy positions.
module lz77_stream_decoder
    import lz77_pkg::*;
#(
    parameter int unsigned        CHAR_W   = CharW,
    parameter int unsigned        SB_DEPTH = 9,
    parameter int unsigned        POS_W    = 4,
    parameter int unsigned        LEN_W    = 3,
    parameter logic [CHAR_W-1:0]  TERM     = CHAR_W'(TermDefault)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [POS_W-1:0]  in_pos,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [CHAR_W-1:0] in_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic              finish,
    output logic              pos_err
);

    state_e            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CHAR_W-1:0] char_q, char_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              pos_err_q, pos_err_d;

    logic              beat;
    logic              accept;
    logic              in_pos_ok;
    logic [CHAR_W-1:0] sb_rd;

    lz77_search_buf #(
        .CHAR_W(CHAR_W),
        .DEPTH (SB_DEPTH),
        .IDX_W (POS_W)
    ) u_search_buf (
        .clk     (clk),
        .reset   (reset),
        .shift_en(beat),
        .shift_in(out_char),
        .rd_idx  (pos_q),
        .rd_data (sb_rd)
    );

    assign in_pos_ok = 32'(in_pos) < SB_DEPTH;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_char  = '0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StCopy: begin
                out_valid = 1'b1;
                out_char  = sb_rd;
            end
            StLit: begin
                out_valid = 1'b1;
                out_char  = char_q;
                // A terminating literal never chains into another tuple.
                in_ready  = out_ready && (char_q != TERM);
            end
            default: ;
        endcase
        beat   = out_valid && out_ready;
        accept = in_valid && in_ready;
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        len_d     = len_q;
        char_d    = char_q;
        cnt_d     = cnt_q;
        pos_err_d = pos_err_q;

        unique case (state_q)
            StCopy: begin
                if (beat) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = StLit;
                    end
                end
            end
            StLit: begin
                if (beat) begin
                    state_d = (char_q == TERM) ? StDone : StIdle;
                end
            end
            default: ;
        endcase

        if (accept) begin
            pos_d  = in_pos;
            len_d  = in_len;
            char_d = in_char;
            cnt_d  = '0;
            if (in_len != '0 && in_pos_ok) begin
                state_d = StCopy;
            end else begin
                state_d = StLit;
            end
            if (in_len != '0 && !in_pos_ok) begin
                pos_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pos_q     <= '0;
            len_q     <= '0;
            char_q    <= '0;
            cnt_q     <= '0;
            pos_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            len_q     <= len_d;
            char_q    <= char_d;
            cnt_q     <= cnt_d;
            pos_err_q <= pos_err_d;
        end
    end

    assign finish  = (state_q == StDone);
    assign pos_err = pos_err_q;

endmodule

// File: tb/tb_lz77_stream_decoder.sv
// Directed self-checking bench for lz77_stream_decoder with hand-computed expected streams.
module tb_lz77_stream_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_pos = '0;
    logic [2:0] in_len = '0;
    logic [7:0] in_char = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_char;
    logic       finish;
    logic       pos_err;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         low_cnt = 0;
    logic [7:0] rx[$];
    int         rx_cyc[$];

    lz77_stream_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pos   (in_pos),
        .in_len   (in_len),
        .in_char  (in_char),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_char (out_char),
        .finish   (finish),
        .pos_err  (pos_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change at posedge+2, so the falling edge is a stable sampling point.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                rx.push_back(out_char);
                rx_cyc.push_back(cyc);
            end
            if (!in_ready) low_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        rx.delete();
        rx_cyc.delete();
        #2;
        reset = 1'b0;
    endtask

    // Presents a tuple and returns just after the edge that accepts it, leaving in_valid high.
    task automatic send(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
        logic acc;
        int   guard;
        in_pos   = p;
        in_len   = l;
        in_char  = c;
        in_valid = 1'b1;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            guard++;
        end
        if (!acc) check("send_timeout", 32'(guard), 32'(0));
    endtask

    task automatic wait_beats(input string tag, input int n);
        int guard;
        guard = 0;
        while (rx.size() < n && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check(tag, 32'(rx.size()), 32'(n));
    endtask

    logic [7:0] exp_t3 [6];
    logic       pat [7];
    logic       prev_stall;
    logic [7:0] prev_char;

    initial begin
        exp_t3 = '{8'h61, 8'h61, 8'h61, 8'h61, 8'h61, 8'h62};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_char", 32'(out_char), 32'(0));
        check("rst_finish", 32'(finish), 32'(0));
        check("rst_pos_err", 32'(pos_err), 32'(0));
        do_reset();

        // literals back to back
        send(4'd0, 3'd0, 8'h61);
        send(4'd0, 3'd0, 8'h62);
        send(4'd0, 3'd0, 8'h63);
        in_valid = 1'b0;
        wait_beats("t1_count", 3);
        check("t1_c0", 32'(rx[0]), 32'h61);
        check("t1_c1", 32'(rx[1]), 32'h62);
        check("t1_c2", 32'(rx[2]), 32'h63);
        check("t1_gap01", 32'(rx_cyc[1] - rx_cyc[0]), 32'(1));
        check("t1_gap12", 32'(rx_cyc[2] - rx_cyc[1]), 32'(1));

        // copy from history after "abc"
        low_cnt = 0;
        send(4'd2, 3'd3, 8'h64);
        in_valid = 1'b0;
        wait_beats("t2_count", 7);
        @(posedge clk);
        #2;
        check("t2_c3", 32'(rx[3]), 32'h61);
        check("t2_c4", 32'(rx[4]), 32'h62);
        check("t2_c5", 32'(rx[5]), 32'h63);
        check("t2_c6", 32'(rx[6]), 32'h64);
        check("t2_in_ready_low", 32'(low_cnt), 32'(3));
        check("t2_pos_err", 32'(pos_err), 32'(0));

        // overlapping copy
        do_reset();
        send(4'd0, 3'd0, 8'h61);
        send(4'd0, 3'd4, 8'h62);
        in_valid = 1'b0;
        wait_beats("t3_count", 6);
        for (int i = 0; i < 6; i++) check($sformatf("t3_c%0d", i), 32'(rx[i]), 32'(exp_t3[i]));

        // copy under backpressure
        do_reset();
        send(4'd0, 3'd0, 8'h61);
        send(4'd0, 3'd0, 8'h62);
        send(4'd0, 3'd0, 8'h63);
        send(4'd2, 3'd3, 8'h64);
        in_valid   = 1'b0;
        prev_stall = 1'b0;
        prev_char  = '0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            @(negedge clk);
            if (prev_stall) check($sformatf("t4_hold%0d", i), 32'(out_char), 32'(prev_char));
            prev_stall = out_valid && !out_ready;
            prev_char  = out_char;
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        wait_beats("t4_count", 7);
        check("t4_c3", 32'(rx[3]), 32'h61);
        check("t4_c4", 32'(rx[4]), 32'h62);
        check("t4_c5", 32'(rx[5]), 32'h63);
        check("t4_c6", 32'(rx[6]), 32'h64);

        // terminator
        do_reset();
        send(4'd0, 3'd0, 8'h24);
        in_pos   = 4'd0;
        in_len   = 3'd0;
        in_char  = 8'h61;
        @(negedge clk);
        check("t5_finish_early", 32'(finish), 32'(0));
        @(negedge clk);
        check("t5_finish", 32'(finish), 32'(1));
        check("t5_in_ready", 32'(in_ready), 32'(0));
        check("t5_out_valid", 32'(out_valid), 32'(0));
        repeat (3) @(negedge clk);
        check("t5_char", 32'(rx[0]), 32'h24);
        check("t5_count", 32'(rx.size()), 32'(1));
        check("t5_sticky", 32'(finish), 32'(1));
        in_valid = 1'b0;
        do_reset();
        #1;
        check("t5_rst_finish", 32'(finish), 32'(0));
        check("t5_rst_in_ready", 32'(in_ready), 32'(1));

        // out-of-range position, then reset mid-copy
        send(4'd9, 3'd2, 8'h78);
        in_valid = 1'b0;
        wait_beats("t6_count", 1);
        repeat (3) @(posedge clk);
        #2;
        check("t6_char", 32'(rx[0]), 32'h78);
        check("t6_only", 32'(rx.size()), 32'(1));
        check("t6_pos_err", 32'(pos_err), 32'(1));
        send(4'd0, 3'd0, 8'h79);
        in_valid = 1'b0;
        wait_beats("t6_count2", 2);
        check("t6_pos_err_sticky", 32'(pos_err), 32'(1));
        send(4'd0, 3'd5, 8'h7a);
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_in_copy", 32'(out_valid), 32'(1));
        reset = 1'b1;
        #1;
        check("t6_abort_out_valid", 32'(out_valid), 32'(0));
        check("t6_abort_in_ready", 32'(in_ready), 32'(1));
        check("t6_abort_out_char", 32'(out_char), 32'(0));
        check("t6_abort_pos_err", 32'(pos_err), 32'(0));
        check("t6_abort_finish", 32'(finish), 32'(0));
        do_reset();
        send(4'd3, 3'd1, 8'h71);
        in_valid = 1'b0;
        wait_beats("t6_count3", 2);
        check("t6_cleared_hist", 32'(rx[0]), 32'h00);
        check("t6_lit_q", 32'(rx[1]), 32'h71);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
